peripheral_dbg_soc_mam_ahb3_slave: RTL

AHB3 slave memory responder; it is the target end of the AHB3 master port driven by the MAM AHB3 bridge.
- Decodes pipelined AHB3 address/data phases, stores data in an internal word array, and returns read data.
- Supports byte/halfword/word writes and programmable wait states; optionally returns ERROR responses.
- Used as the SoC-side debug memory and as the MAM bench target.

---
 rtl/peripheral_dbg_soc_mam_ahb3_slave.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/peripheral_dbg_soc_mam_ahb3_slave.sv
// AHB3 slave memory responder with byte-lane writes and programmable wait states.
// Optional ERROR responses for out-of-range/oversize transfers: PERIPHERAL_DBG_SOC_MAM_AHB3_SLAVE_ERR_EN.
module peripheral_dbg_soc_mam_ahb3_slave #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     PLEN        = 32,
  parameter int unsigned     MEM_WORDS   = 256,
  parameter logic [PLEN-1:0] BASE_ADDR   = '0,
  parameter int unsigned     WAIT_STATES = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ahb3_hsel_i,
  input  logic [PLEN-1:0] ahb3_haddr_i,
  input  logic [XLEN-1:0] ahb3_hwdata_i,
  input  logic            ahb3_hwrite_i,
  input  logic [2:0]      ahb3_hsize_i,
  input  logic [2:0]      ahb3_hburst_i,
  input  logic [3:0]      ahb3_hprot_i,
  input  logic [1:0]      ahb3_htrans_i,
  input  logic            ahb3_hmastlock_i,
  input  logic            ahb3_hready_i,
  output logic [XLEN-1:0] ahb3_hrdata_o,
  output logic            ahb3_hreadyout_o,
  output logic            ahb3_hresp_o
);

  localparam int unsigned LANES = XLEN / 8;
  localparam int unsigned LB    = $clog2(LANES);
  localparam int unsigned AW    = $clog2(MEM_WORDS);
  localparam int unsigned OW    = AW + LB;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
`ifdef PERIPHERAL_DBG_SOC_MAM_AHB3_SLAVE_ERR_EN
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;
`endif

  // Halfwords are forced to an even lane; anything wider covers the whole word.
  function automatic logic [LANES-1:0] lane_mask(input logic [2:0] size, input logic [LB-1:0] lane);
    logic [LANES-1:0] m;
    case (size)
      3'd0:    m = LANES'(1) << lane;
      3'd1:    m = LANES'(3) << (lane & ~LB'(1));
      default: m = '1;
    endcase
    return m;
  endfunction

  logic [2:0]       state_q, state_d, start_s;
  logic [OW-1:0]    addr_q, addr_d;
  logic             write_q, write_d;
  logic [2:0]       size_q, size_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             hreadyout_q, hreadyout_d;
  logic [XLEN-1:0]  mem_q [MEM_WORDS];
  logic [PLEN-1:0]  offset_s;
  logic             accept_s, err_s;
  logic [AW-1:0]    idx_s;
  logic [LANES-1:0] be_s;
  logic             unused_s;

  assign offset_s = ahb3_haddr_i - BASE_ADDR;
  assign accept_s = ahb3_hsel_i & ahb3_hready_i & ahb3_htrans_i[1];
  assign idx_s    = addr_q[OW-1:LB];
  assign be_s     = lane_mask(size_q, addr_q[LB-1:0]);
  assign unused_s = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i, ahb3_htrans_i[0], offset_s[PLEN-1:OW]};

`ifdef PERIPHERAL_DBG_SOC_MAM_AHB3_SLAVE_ERR_EN
  assign err_s = (offset_s[PLEN-1:OW] != '0) || (ahb3_hsize_i > 3'(LB));
`else
  assign err_s = 1'b0;
`endif

  // State entered by an accepted address phase.
  always_comb begin
`ifdef PERIPHERAL_DBG_SOC_MAM_AHB3_SLAVE_ERR_EN
    if (err_s) start_s = S_ERR1;
    else if (WAIT_STATES > 0) start_s = S_WAIT;
    else start_s = S_DATA;
`else
    if (err_s || (WAIT_STATES == 0)) start_s = S_DATA;
    else start_s = S_WAIT;
`endif
  end

  // Transfer sequencing; IDLE, DATA and ERR2 share the accept-or-idle arm.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_DATA;
        else state_d = S_WAIT;
      end
`ifdef PERIPHERAL_DBG_SOC_MAM_AHB3_SLAVE_ERR_EN
      S_ERR1: state_d = S_ERR2;
`endif
      default: begin
        if (accept_s) begin
          addr_d  = offset_s[OW-1:0];
          write_d = ahb3_hwrite_i;
          size_d  = ahb3_hsize_i;
          cnt_d   = 4'(WAIT_STATES);
          state_d = start_s;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Ready is low only while stretching a data phase.
  always_comb begin
    case (state_d)
      S_WAIT:  hreadyout_d = 1'b0;
`ifdef PERIPHERAL_DBG_SOC_MAM_AHB3_SLAVE_ERR_EN
      S_ERR1:  hreadyout_d = 1'b0;
`endif
      default: hreadyout_d = 1'b1;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      cnt_q       <= 4'd0;
      hreadyout_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
    end
  end

  // Writes commit at the edge that ends their data phase, so a following read sees them.
  always_ff @(posedge clk_i) begin
    if (state_q == S_DATA && write_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_s[i]) mem_q[idx_s][i*8 +: 8] <= ahb3_hwdata_i[i*8 +: 8];
      end
    end
  end

`ifdef PERIPHERAL_DBG_SOC_MAM_AHB3_SLAVE_ERR_EN
  logic hresp_q, hresp_d;

  // Both ERROR cycles carry HRESP high.
  always_comb begin
    case (state_d)
      S_ERR1, S_ERR2: hresp_d = 1'b1;
      default:        hresp_d = 1'b0;
    endcase
  end

  // Response register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hresp_q <= 1'b0;
    else hresp_q <= hresp_d;
  end

  assign ahb3_hresp_o = hresp_q;
`else
  assign ahb3_hresp_o = 1'b0;
`endif

  assign ahb3_hreadyout_o = hreadyout_q;
  assign ahb3_hrdata_o    = (state_q == S_DATA && !write_q) ? mem_q[idx_s] : '0;

endmodule
